ualink_port_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter for the five AXI-Stream slave ports of ualink_turbo64.

---
 rtl/ualink_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_ualink_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ualink_port_arbiter.sv
// Purpose : packet-granular round-robin arbiter for the ualink_turbo64 AXI-Stream slave ports.
// Latency : request-to-grant 1 clk; op_valid/op_write/op_read registered 1 clk after the header beat.
// Backpr. : s_tready = grant & m_tready (combinational); grant is held until tlast, no preemption.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   s_tvalid, s_tlast    per-port stream handshake/last flags (NUM_PORTS wide)
//   s_opcode             per-port header tdata[15:8], port p at [8p+7:8p]
//   s_tready             per-port ready, only the granted port follows m_tready
//   m_tready             ready of the shared output/ualink_dpmem path
//   grant, grant_idx     registered one-hot grant and its binary index
//   busy                 a packet is in flight
//   op_valid             one-cycle pulse when the granted packet's opcode is captured
//   op_write, op_read    decoded captured opcode, held until the next capture
//   timeout_err          sticky forced-release flag
//
// Optional feature: define UALINK_ARB_TIMEOUT_EN to release a grant whose port stalls for
// TIMEOUT cycles without an accepted beat. Without it the grant is held indefinitely and
// timeout_err is tied low.
module ualink_port_arbiter #(
    parameter int         NUM_PORTS = 5,
    parameter int         IDX_W     = 3,
    parameter logic [7:0] WR_OPCODE = 8'hFE,
    parameter logic [7:0] RD_OPCODE = 8'hFF,
    parameter int         TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   s_tvalid,
    input  logic [NUM_PORTS-1:0]   s_tlast,
    input  logic [NUM_PORTS*8-1:0] s_opcode,
    output logic [NUM_PORTS-1:0]   s_tready,
    input  logic                   m_tready,
    output logic [NUM_PORTS-1:0]   grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   busy,
    output logic                   op_valid,
    output logic                   op_write,
    output logic                   op_read,
    output logic                   timeout_err
);

    // Elaboration-time parameter sanity checks.
    if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
        $error("ualink_port_arbiter: NUM_PORTS must be 2..8");
    end
    if ((2 ** IDX_W) < NUM_PORTS) begin : g_bad_idx_w
        $error("ualink_port_arbiter: IDX_W too narrow for NUM_PORTS");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("ualink_port_arbiter: TIMEOUT must fit the 8-bit idle counter");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 op_valid_q, op_valid_d;
    logic                 op_write_q, op_write_d;
    logic                 op_read_q, op_read_d;

    logic                 busy_w;
    logic                 beat;
    logic                 last_sel;
    logic [7:0]           hdr_op;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    int                   cand;
    logic                 timeout_hit;

    assign busy_w   = (state_q != S_IDLE);
    // grant_q is zero in IDLE, so masking by it both selects the owner and blocks idle beats.
    assign s_tready = grant_q & {NUM_PORTS{m_tready}};
    assign beat     = busy_w & m_tready & (|(s_tvalid & grant_q));
    assign last_sel = |(s_tlast & grant_q);

    // Opcode byte of the granted port.
    always_comb begin
        hdr_op = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q[p]) begin
                hdr_op = s_opcode[8*p +: 8];
            end
        end
    end

    // Round-robin search: first requester after the last winner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = (int'(ptr_q) + i) % NUM_PORTS;
            if (!win_found && s_tvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        op_valid_d = 1'b0;
        op_write_d = op_write_q;
        op_read_d  = op_read_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = NUM_PORTS'(1) << win_idx;
                    idx_d   = win_idx;
                    ptr_d   = win_idx;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (beat) begin
                    op_valid_d = 1'b1;
                    op_write_d = (hdr_op == WR_OPCODE);
                    op_read_d  = (hdr_op == RD_OPCODE);
                    state_d    = last_sel ? S_IDLE : S_BURST;
                end
            end
            S_BURST: begin
                if (beat && last_sel) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Forced release; ptr already points at the stalled port, so the next
        // search naturally starts past it.
        if (timeout_hit) begin
            state_d = S_IDLE;
        end

        if (state_d == S_IDLE) begin
            grant_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            idx_q      <= '0;
            ptr_q      <= IDX_W'(NUM_PORTS - 1);
            op_valid_q <= 1'b0;
            op_write_q <= 1'b0;
            op_read_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            op_valid_q <= op_valid_d;
            op_write_q <= op_write_d;
            op_read_q  <= op_read_d;
        end
    end

`ifdef UALINK_ARB_TIMEOUT_EN
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       to_err_q;

    // Counts consecutive in-packet cycles without an accepted beat.
    always_comb begin
        to_cnt_d = to_cnt_q + 8'd1;
        if (!busy_w || beat) begin
            to_cnt_d = '0;
        end
    end

    assign timeout_hit = busy_w & ~beat & (to_cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_q | timeout_hit;
        end
    end

    assign timeout_err = to_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign busy      = busy_w;
    assign op_valid  = op_valid_q;
    assign op_write  = op_write_q;
    assign op_read   = op_read_q;

endmodule

// File: tb/tb_ualink_port_arbiter.sv
// Purpose : self-checking bench for ualink_port_arbiter (table vectors + packet sequences).
// Latency : checks registered outputs 1 ns after the rising edge, s_tready 1 ns after the falling edge.
// Backpr. : a per-port packet source honours s_tready and m_tready.
module tb_ualink_port_arbiter;

    localparam int NP = 5;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   s_tvalid, s_tlast, s_tready, grant;
    logic [NP*8-1:0] s_opcode;
    logic            m_tready;
    logic [IW-1:0]   grant_idx;
    logic            busy, op_valid, op_write, op_read, timeout_err;

    always #5 clk = ~clk;

    ualink_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_opcode    (s_opcode),
        .s_tready    (s_tready),
        .m_tready    (m_tready),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .op_valid    (op_valid),
        .op_write    (op_write),
        .op_read     (op_read),
        .timeout_err (timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- packet source model ----------------
    int          remain[NP];     // beats left in current packet, 0 = none
    int          plen[NP];       // length used for reloads
    int          pleft[NP];      // extra packets after the current one
    int          start_at[NP];   // first cycle tvalid may rise
    int          hold_after[NP]; // drop tvalid for good after this many beats (-1 = never)
    int          beats[NP];
    logic [7:0]  pop[NP];
    logic [NP-1:0] last_acc;
    logic [NP-1:0] trdy_pre;
    logic        toggle;
    int          cyc;
    int          multi_err = 0;

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; s_tvalid = '0; s_tlast = '0; s_opcode = '0; m_tready = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < NP; p++) begin
            remain[p] = 0; plen[p] = 0; pleft[p] = 0; start_at[p] = 0;
            hold_after[p] = -1; beats[p] = 0; pop[p] = 8'h00;
        end
        cyc = 0; toggle = 1'b0; last_acc = '0;
    endtask

    task automatic step();
        logic [NP-1:0] acc;
        @(negedge clk);
        last_acc = '0;
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p] = (remain[p] > 0) && (cyc >= start_at[p]) &&
                          ((hold_after[p] < 0) || (beats[p] < hold_after[p]));
            s_tlast[p]  = (remain[p] == 1);
            s_opcode[8*p +: 8] = pop[p];
        end
        m_tready = toggle ? cyc[0] : 1'b1;
        #1;
        trdy_pre = s_tready;
        acc = s_tready & s_tvalid;
        if ($countones(s_tready) > 1) multi_err++;
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                beats[p]++;
                if (remain[p] == 1) begin
                    last_acc[p] = 1'b1;
                    if (pleft[p] > 0) begin
                        remain[p] = plen[p];
                        pleft[p]--;
                    end else begin
                        remain[p] = 0;
                    end
                end else begin
                    remain[p]--;
                end
            end
        end
        cyc++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic [4:0]  vld;
        logic [4:0]  last;
        logic [39:0] op;
        logic        mrdy;
        logic [4:0]  e_trdy;
        logic [4:0]  e_grant;
        logic [2:0]  e_idx;
        logic        e_busy;
        logic        e_opv;
        logic        e_opw;
        logic        e_opr;
    } vec_t;

    vec_t vt[16];

    initial begin
        int  nopv;
        int  opw_seen;
        int  n;
        logic done;
        logic prev_busy;
        int  gap;
        int  gseq[$];
        int  gaps[$];
        int  op_idx[$];
        int  op_w[$];
        int  op_r[$];
        int  trdy_bad;
        int  exp_seq[6];

        // rst vld   last  op                 mrdy trdy  grant idx  busy opv opw opr
        vt[0]  = '{1'b1, 5'h00, 5'h00, 40'h0000000000, 1'b1, 5'h00, 5'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 5'h10, 5'h10, 40'h0000000000, 1'b1, 5'h00, 5'h10, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 5'h10, 5'h10, 40'h0000000000, 1'b1, 5'h10, 5'h00, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 5'h00, 5'h00, 40'h0000000000, 1'b1, 5'h00, 5'h00, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 5'h01, 5'h00, 40'h00000000FE, 1'b1, 5'h00, 5'h01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 5'h01, 5'h00, 40'h00000000FE, 1'b0, 5'h00, 5'h01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 5'h01, 5'h00, 40'h00000000FE, 1'b1, 5'h01, 5'h01, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 5'h08, 5'h00, 40'h00FF0000FE, 1'b1, 5'h01, 5'h01, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 5'h09, 5'h01, 40'h00FF0000FE, 1'b1, 5'h01, 5'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 5'h08, 5'h00, 40'h00FF000000, 1'b1, 5'h00, 5'h08, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[10] = '{1'b0, 5'h08, 5'h08, 40'h00FF000000, 1'b1, 5'h08, 5'h00, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[11] = '{1'b0, 5'h00, 5'h00, 40'h0000000000, 1'b1, 5'h00, 5'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[12] = '{1'b0, 5'h01, 5'h00, 40'h0000000000, 1'b1, 5'h00, 5'h01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[13] = '{1'b0, 5'h01, 5'h00, 40'h0000000000, 1'b1, 5'h01, 5'h01, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[14] = '{1'b1, 5'h01, 5'h00, 40'h0000000000, 1'b1, 5'h01, 5'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[15] = '{1'b0, 5'h00, 5'h00, 40'h0000000000, 1'b1, 5'h00, 5'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; s_tvalid = '0; s_tlast = '0; s_opcode = '0; m_tready = 1'b1;

        // ---- Test 1: reset 50 clk, port 0 write header + 32 payload beats ----
        do_reset(50);
        chk("t1.reset_grant", grant, 5'h00);
        chk("t1.reset_busy", busy, 1'b0);
        chk("t1.reset_terr", timeout_err, 1'b0);
        remain[0] = 33; pop[0] = 8'hFE;
        step();
        chk("t1.grant_latency", grant, 5'b00001);
        chk("t1.busy", busy, 1'b1);
        nopv = 0; opw_seen = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            step();
            if (op_valid) begin nopv++; opw_seen = op_write; end
            if (last_acc[0]) begin
                done = 1'b1;
                chk("t1.grant_after_last", grant, 5'h00);
                chk("t1.busy_after_last", busy, 1'b0);
            end
        end
        chk("t1.completed", done, 1'b1);
        chk("t1.op_valid_pulses", nopv, 1);
        chk("t1.op_write", opw_seen, 1);
        chk("t1.beats", beats[0], 33);

        // ---- vector table ----
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0; s_opcode = '0; m_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            reset = vt[k].rst; s_tvalid = vt[k].vld; s_tlast = vt[k].last;
            s_opcode = vt[k].op; m_tready = vt[k].mrdy;
            #1;
            chk($sformatf("v%0d.tready", k), s_tready, vt[k].e_trdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.grant", k), grant, vt[k].e_grant);
            chk($sformatf("v%0d.idx", k), grant_idx, vt[k].e_idx);
            chk($sformatf("v%0d.busy", k), busy, vt[k].e_busy);
            chk($sformatf("v%0d.op_valid", k), op_valid, vt[k].e_opv);
            chk($sformatf("v%0d.op_write", k), op_write, vt[k].e_opw);
            chk($sformatf("v%0d.op_read", k), op_read, vt[k].e_opr);
            chk($sformatf("v%0d.timeout_err", k), timeout_err, 1'b0);
        end

        // ---- Test 2: all ports request continuously, 4-beat packets ----
        do_reset(3);
        for (int p = 0; p < NP; p++) begin remain[p] = 4; plen[p] = 4; pop[p] = 8'(p); end
        pleft[0] = 1;
        exp_seq = '{0, 1, 2, 3, 4, 0};
        prev_busy = 1'b0; gap = 0;
        for (int c = 0; c < 200 && gseq.size() < 6; c++) begin
            step();
            if (busy && !prev_busy) begin
                gseq.push_back(int'(grant_idx));
                gaps.push_back(gap);
                chk($sformatf("t2.onehot%0d", gseq.size() - 1), grant,
                    64'(5'b00001 << exp_seq[gseq.size() - 1]));
            end
            gap = busy ? 0 : gap + 1;
            prev_busy = busy;
        end
        chk("t2.grant_count", gseq.size(), 6);
        for (int i = 0; i < gseq.size(); i++) begin
            chk($sformatf("t2.seq%0d", i), gseq[i], exp_seq[i]);
            if (i > 0) chk($sformatf("t2.gap%0d", i), gaps[i], 1);
        end

        // ---- Test 3: port 3 read request while port 1 mid-packet ----
        do_reset(3);
        remain[1] = 6; pop[1] = 8'h00;
        remain[3] = 3; pop[3] = 8'hFF; start_at[3] = 3;
        gseq.delete(); prev_busy = 1'b0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            step();
            if (busy && !prev_busy) gseq.push_back(int'(grant_idx));
            if (op_valid) begin
                op_idx.push_back(int'(grant_idx));
                op_w.push_back(int'(op_write));
                op_r.push_back(int'(op_read));
            end
            if (last_acc[3]) done = 1'b1;
            prev_busy = busy;
        end
        chk("t3.completed", done, 1'b1);
        chk("t3.grants", gseq.size(), 2);
        chk("t3.op_count", op_idx.size(), 2);
        if (gseq.size() == 2) begin
            chk("t3.first", gseq[0], 1);
            chk("t3.second", gseq[1], 3);
        end
        if (op_idx.size() == 2) begin
            chk("t3.op0_read", op_r[0], 0);
            chk("t3.op1_idx", op_idx[1], 3);
            chk("t3.op1_read", op_r[1], 1);
            chk("t3.op1_write", op_w[1], 0);
        end

        // ---- Test 4: m_tready toggling during a 34-beat port 2 packet ----
        do_reset(3);
        remain[2] = 34; pop[2] = 8'hFE; toggle = 1'b1;
        trdy_bad = 0; done = 1'b0;
        step(); // request cycle: arbiter idle, nothing ready
        if (trdy_pre !== 5'h00) trdy_bad++;
        for (int c = 0; c < 200 && !done; c++) begin
            step();
            if (trdy_pre !== {2'b00, m_tready, 2'b00}) trdy_bad++;
            if (last_acc[2]) done = 1'b1;
        end
        chk("t4.completed", done, 1'b1);
        chk("t4.tready_follow", trdy_bad, 0);
        chk("t4.beats", beats[2], 34);

        // ---- Test 6b: port 1 stalls after its header, port 2 waiting ----
        do_reset(3);
        remain[1] = 5; pop[1] = 8'hFE; hold_after[1] = 1;
        remain[2] = 2; pop[2] = 8'hFF; start_at[2] = 3;
        step();
        step();
        chk("t6.hdr_accepted", beats[1], 1);
`ifdef UALINK_ARB_TIMEOUT_EN
        n = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            step();
            n++;
            if (!busy) done = 1'b1;
        end
        chk("t6.released", done, 1'b1);
        chk("t6.stall_cycles", n, 64);
        chk("t6.timeout_err", timeout_err, 1'b1);
        step();
        chk("t6.next_grant", grant, 5'b00100);
        chk("t6.next_idx", grant_idx, 3'd2);
`else
        repeat (80) step();
        chk("t6.held_busy", busy, 1'b1);
        chk("t6.held_grant", grant, 5'b00010);
        chk("t6.no_timeout_err", timeout_err, 1'b0);
`endif

        chk("all.single_tready", multi_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
